// File: rtl/alsu_gen.sv
// Two-stage arithmetic/logic/shift unit with registered inputs and result,
// plus an LED blink sequencer that flags invalid operations.
module alsu_gen #(
    parameter int WIDTH          = 3,
    parameter     INPUT_PRIORITY = "A",
    parameter     FULL_ADDER     = "on",
    parameter int BLINK_PERIOD   = 4,
    parameter int BLINK_TOGGLES  = 50
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    input  logic [2:0]           opcode,
    input  logic                 cin,
    input  logic                 serial_in,
    input  logic                 direction,
    input  logic                 red_op_A,
    input  logic                 red_op_B,
    input  logic                 bypass_A,
    input  logic                 bypass_B,
    output logic [2*WIDTH-1:0]   out,
    output logic                 out_valid,
    output logic [15:0]          leds,
    output logic                 error
);

    localparam int   W2      = 2 * WIDTH;
    localparam logic PRI_A   = (INPUT_PRIORITY == "A");
    localparam logic USE_CIN = (FULL_ADDER == "on");
    localparam int   PW      = $clog2(BLINK_PERIOD + 1);
    localparam int   TW      = $clog2(BLINK_TOGGLES + 1);
    localparam logic [PW-1:0] PER_LAST = PW'(BLINK_PERIOD - 1);
    localparam logic [TW-1:0] TOG_LAST = TW'(BLINK_TOGGLES - 1);

    typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_BLINK = 1'b1} blink_state_t;

    logic [WIDTH-1:0] a_r, b_r;
    logic [2:0]       op_r;
    logic             cin_r, ser_r, dir_r, red_a_r, red_b_r, byp_a_r, byp_b_r, v1_r;
    logic [W2-1:0]    out_r, res_s, prod_s;
    logic [WIDTH:0]   sum_s;
    logic [WIDTH-1:0] red_src_s;
    logic             out_valid_r, inv_s, trig_s, error_r;
    logic [15:0]      leds_r, leds_n;
    logic [PW-1:0]    per_cnt_r, per_n;
    logic [TW-1:0]    tog_cnt_r, tog_n;
    blink_state_t     state_r, state_n;

    function automatic logic red_bit(input logic is_xor, input logic [WIDTH-1:0] v);
        if (is_xor) begin
            red_bit = ^v;
        end else begin
            red_bit = &v;
        end
    endfunction

    // Stage 1: capture operands when qualified; valid flag tracks in_valid every cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r <= '0; b_r <= '0; op_r <= 3'd0;
            cin_r <= 1'b0; ser_r <= 1'b0; dir_r <= 1'b0;
            red_a_r <= 1'b0; red_b_r <= 1'b0; byp_a_r <= 1'b0; byp_b_r <= 1'b0;
            v1_r <= 1'b0;
        end else begin
            v1_r <= in_valid;
            if (in_valid) begin
                a_r <= A; b_r <= B; op_r <= opcode;
                cin_r <= cin; ser_r <= serial_in; dir_r <= direction;
                red_a_r <= red_op_A; red_b_r <= red_op_B;
                byp_a_r <= bypass_A; byp_b_r <= bypass_B;
            end else begin
                a_r <= a_r; b_r <= b_r; op_r <= op_r;
            end
        end
    end

    // Result selection: bypass first, then legality, then the opcode itself
    always_comb begin
        res_s     = '0;
        inv_s     = 1'b0;
        sum_s     = {1'b0, a_r} + {1'b0, b_r} + {{WIDTH{1'b0}}, cin_r & USE_CIN};
        prod_s    = {{WIDTH{1'b0}}, a_r} * {{WIDTH{1'b0}}, b_r};
        red_src_s = (red_a_r && (!red_b_r || PRI_A)) ? a_r : b_r;
        if (byp_a_r && (!byp_b_r || PRI_A)) begin
            res_s = {{WIDTH{1'b0}}, a_r};
        end else if (byp_b_r) begin
            res_s = {{WIDTH{1'b0}}, b_r};
        end else if ((op_r[2:1] == 2'b11) || ((red_a_r || red_b_r) && (op_r[2:1] != 2'b00))) begin
            inv_s = 1'b1;
        end else begin
            case (op_r)
                3'd0, 3'd1: begin
                    if (red_a_r || red_b_r) begin
                        res_s = {{(W2-1){1'b0}}, red_bit(op_r[0], red_src_s)};
                    end else if (op_r[0]) begin
                        res_s = {{WIDTH{1'b0}}, a_r ^ b_r};
                    end else begin
                        res_s = {{WIDTH{1'b0}}, a_r & b_r};
                    end
                end
                3'd2:    res_s = {{(WIDTH-1){1'b0}}, sum_s};
                3'd3:    res_s = prod_s;
                3'd4:    res_s = dir_r ? {out_r[W2-2:0], ser_r} : {ser_r, out_r[W2-1:1]};
                3'd5:    res_s = dir_r ? {out_r[W2-2:0], out_r[W2-1]} : {out_r[0], out_r[W2-1:1]};
                default: res_s = '0;
            endcase
        end
    end

    assign trig_s = v1_r & inv_s;

    // Stage 2: result register updates only for a qualified stage-1 entry
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_r       <= '0;
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= v1_r;
            if (v1_r) begin
                out_r <= res_s;
            end else begin
                out_r <= out_r;
            end
        end
    end

    // Blink sequencer next-state; a new invalid op always restarts the pattern
    always_comb begin
        state_n = state_r;
        leds_n  = leds_r;
        per_n   = per_cnt_r;
        tog_n   = tog_cnt_r;
        if (trig_s) begin
            state_n = ST_BLINK;
            leds_n  = 16'hFFFF;
            per_n   = '0;
            tog_n   = '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    leds_n = 16'h0000;
                    per_n  = '0;
                    tog_n  = '0;
                end
                ST_BLINK: begin
                    if (per_cnt_r == PER_LAST) begin
                        per_n = '0;
                        if (tog_cnt_r == TOG_LAST) begin
                            leds_n  = 16'h0000;
                            tog_n   = '0;
                            state_n = ST_IDLE;
                        end else begin
                            leds_n = ~leds_r;
                            tog_n  = tog_cnt_r + TW'(1);
                        end
                    end else begin
                        per_n = per_cnt_r + PW'(1);
                    end
                end
                default: begin
                    state_n = ST_IDLE;
                    leds_n  = 16'h0000;
                    per_n   = '0;
                    tog_n   = '0;
                end
            endcase
        end
    end

    // Blink sequencer registers; error mirrors the registered state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            leds_r    <= 16'h0000;
            per_cnt_r <= '0;
            tog_cnt_r <= '0;
            error_r   <= 1'b0;
        end else begin
            state_r   <= state_n;
            leds_r    <= leds_n;
            per_cnt_r <= per_n;
            tog_cnt_r <= tog_n;
            error_r   <= (state_n == ST_BLINK);
        end
    end

    assign out       = out_r;
    assign out_valid = out_valid_r;
    assign leds      = leds_r;
    assign error     = error_r;

endmodule

// File: tb/tb_alsu_gen.sv
// Scoreboard bench for alsu_gen (default parameters): stimulus pushes expected
// results, a monitor pops them on out_valid and tracks the LED blink pattern.
module tb_alsu_gen;
    localparam int W = 3;
    localparam int W2 = 6;
    localparam int BP = 4;
    localparam int BT = 50;
    localparam int IDLE_T = 100000;

    typedef struct {
        logic [W2-1:0] val;
        bit            inv;
        int            cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic in_valid = 1'b0;
    logic [W-1:0] A = '0;
    logic [W-1:0] B = '0;
    logic [2:0] opcode = 3'd0;
    logic cin = 1'b0, serial_in = 1'b0, direction = 1'b0;
    logic red_op_A = 1'b0, red_op_B = 1'b0, bypass_A = 1'b0, bypass_B = 1'b0;
    logic [W2-1:0] out;
    logic out_valid;
    logic [15:0] leds;
    logic error;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   blink_t = IDLE_T;
    int   model_out = 0;

    alsu_gen dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .A(A), .B(B), .opcode(opcode),
        .cin(cin), .serial_in(serial_in), .direction(direction),
        .red_op_A(red_op_A), .red_op_B(red_op_B), .bypass_A(bypass_A), .bypass_B(bypass_B),
        .out(out), .out_valid(out_valid), .leds(leds), .error(error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference behaviour in plain integer arithmetic
    function automatic int model(input int a, input int b, input int op, input bit c, input bit s,
                                 input bit d, input bit ra, input bit rb, input bit ba, input bit bb,
                                 input int cur, output bit inv);
        int sel;
        inv = 1'b0;
        if (ba || bb) return ba ? a : b;
        if (op >= 6 || ((ra || rb) && op >= 2)) begin
            inv = 1'b1;
            return 0;
        end
        case (op)
            0, 1: begin
                if (ra || rb) begin
                    sel = ra ? a : b;
                    if (op == 0) return (sel == 7) ? 1 : 0;
                    return $countones(sel) % 2;
                end
                return (op == 0) ? (a & b) : (a ^ b);
            end
            2: return a + b + (c ? 1 : 0);
            3: return a * b;
            4: return d ? (cur * 2 + (s ? 1 : 0)) % 64 : (s ? 32 : 0) + cur / 2;
            default: return d ? (cur * 2) % 64 + cur / 32 : (cur % 2) * 32 + cur / 2;
        endcase
    endfunction

    task automatic issue(input int a, input int b, input int op, input bit c, input bit s, input bit d,
                         input bit ra, input bit rb, input bit ba, input bit bb);
        bit   inv;
        int   r;
        exp_t e;
        @(negedge clk);
        in_valid = 1'b1;
        A = a[W-1:0]; B = b[W-1:0]; opcode = op[2:0];
        cin = c; serial_in = s; direction = d;
        red_op_A = ra; red_op_B = rb; bypass_A = ba; bypass_B = bb;
        r = model(a, b, op, c, s, d, ra, rb, ba, bb, model_out, inv);
        model_out = r;
        e.val = r[W2-1:0];
        e.inv = inv;
        e.cyc = cyc;
        q.push_back(e);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            in_valid = 1'b0;
            A = W'($urandom); B = W'($urandom); opcode = 3'($urandom);
        end
    endtask

    // Monitor: pop on out_valid, detect missing/stray results, track LED pattern
    initial begin
        exp_t e;
        logic [15:0] exp_leds;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            if (out_valid) begin
                if (q.size() == 0) begin
                    chk("stray_out_valid", 32'(out_valid), 32'd0);
                end else begin
                    e = q.pop_front();
                    chk("out", 32'(out), 32'(e.val));
                    chk("latency", 32'(cyc - e.cyc), 32'd2);
                    if (e.inv) blink_t = 0;
                end
            end else if (q.size() > 0 && (cyc - q[0].cyc) >= 2) begin
                e = q.pop_front();
                chk("missing_out_valid", 32'(out_valid), 32'd1);
            end
            if (blink_t < BP * BT) begin
                exp_leds = (((blink_t / BP) % 2) == 0) ? 16'hFFFF : 16'h0000;
                chk("leds", 32'(leds), 32'(exp_leds));
                chk("error", 32'(error), 32'd1);
            end else begin
                chk("leds_idle", 32'(leds), 32'd0);
                chk("error_idle", 32'(error), 32'd0);
            end
            if (blink_t < IDLE_T) blink_t++;
        end
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_out", 32'(out), 32'd0);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_leds", 32'(leds), 32'd0);
        chk("rst_error", 32'(error), 32'd0);
        rst_n = 1'b1;

        issue(5, 6, 2, 1, 0, 0, 0, 0, 0, 0);          // 12
        idle(3);
        issue(7, 7, 3, 0, 0, 0, 0, 0, 0, 0);          // 49
        issue(3, 2, 0, 0, 0, 0, 0, 0, 0, 0);          // 2
        issue(0, 0, 2, 1, 0, 0, 0, 0, 0, 0);          // 1
        issue(0, 0, 5, 0, 0, 0, 0, 0, 0, 0);          // rotate right -> 32
        issue(0, 0, 4, 0, 1, 1, 0, 0, 0, 0);          // shift left in 1 -> 1
        issue(3, 5, 7, 0, 0, 0, 0, 0, 1, 1);          // bypass A -> 3
        issue(6, 0, 1, 0, 0, 0, 1, 1, 0, 0);          // xor-reduce A=6 -> 0
        issue(7, 0, 0, 0, 0, 0, 1, 0, 0, 0);          // and-reduce A=7 -> 1
        idle(3);

        issue(1, 1, 6, 0, 0, 0, 0, 0, 0, 0);          // invalid, blink starts
        idle(99);
        issue(2, 2, 7, 0, 0, 0, 0, 0, 0, 0);          // restart mid-blink
        issue(4, 3, 3, 0, 0, 0, 0, 0, 0, 0);          // valid op during blink
        idle(BP * BT + 10);

        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(3) == 0) begin
                idle(1);
            end else begin
                issue($urandom_range(7), $urandom_range(7), $urandom_range(7),
                      1'($urandom), 1'($urandom), 1'($urandom),
                      $urandom_range(3) == 0, $urandom_range(3) == 0,
                      $urandom_range(7) == 0, $urandom_range(7) == 0);
            end
        end
        idle(5);

        issue(1, 1, 7, 0, 0, 0, 0, 0, 0, 0);          // blink active for reset test
        idle(20);
        issue(7, 6, 3, 0, 0, 0, 0, 0, 0, 0);          // in flight when reset hits
        @(posedge clk);
        #3;
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out", 32'(out), 32'd0);
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_leds", 32'(leds), 32'd0);
        chk("mid_rst_error", 32'(error), 32'd0);
        q.delete();
        blink_t = IDLE_T;
        model_out = 0;
        @(negedge clk);
        rst_n = 1'b1;
        idle(5);
        issue(2, 3, 1, 0, 0, 0, 0, 0, 0, 0);          // 1 after reset
        issue(0, 0, 4, 0, 1, 0, 0, 0, 0, 0);          // shift right in 1 -> 32
        idle(1);

        for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
        chk("drain", 32'(q.size()), 32'd0);
        idle(BP * BT + 5);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
